// File: rtl/interval_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : interval_arbiter
// Description : Round-robin owner of a shared CW-bit interval counter; runs
//               the granted requester for its latched duration, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module interval_arbiter #(
    parameter int NREQ = 4,
    parameter int CW   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CW-1:0]   dur,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic                 cnt_en,
    output logic [CW-1:0]        count
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   owner_q;
    logic [IW-1:0]   ptr_q;
    logic [CW-1:0]   target_q;
    logic [CW-1:0]   count_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] done_q;
    logic            busy_q;
    logic            cnt_en_q;

    logic [IW:0]     cand;
    logic            arb_vld;
    logic [IW-1:0]   arb_idx;
    logic [IW:0]     ptr_sum;
    logic [IW-1:0]   ptr_d;
    logic            last_cycle;

    // Scan offsets high-to-low so the smallest offset from ptr wins.
    always_comb begin
        arb_vld = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (req[cand[IW-1:0]]) begin
                arb_vld = 1'b1;
                arb_idx = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        ptr_sum = {1'b0, owner_q} + (IW+1)'(1);
        ptr_d   = (ptr_sum >= (IW+1)'(NREQ)) ? '0 : ptr_sum[IW-1:0];
    end

    // target of zero wraps through all 2^CW counts before matching.
    assign last_cycle = (count_q == (target_q - CW'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            ptr_q    <= '0;
            target_q <= '0;
            count_q  <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            cnt_en_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= '0;
                    if (arb_vld) begin
                        state_q  <= S_RUN;
                        owner_q  <= arb_idx;
                        target_q <= dur[arb_idx*CW +: CW];
                        count_q  <= '0;
                        gnt_q    <= {{(NREQ-1){1'b0}}, 1'b1} << arb_idx;
                        busy_q   <= 1'b1;
                        cnt_en_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (last_cycle) begin
                        state_q  <= S_DONE;
                        count_q  <= '0;
                        gnt_q    <= '0;
                        cnt_en_q <= 1'b0;
                        done_q   <= {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
                        ptr_q    <= ptr_d;
                    end else begin
                        count_q  <= count_q + CW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= S_IDLE;
                    gnt_q    <= '0;
                    done_q   <= '0;
                    busy_q   <= 1'b0;
                    cnt_en_q <= 1'b0;
                    count_q  <= '0;
                end
            endcase
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign cnt_en = cnt_en_q;
    assign count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_interval_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_interval_arbiter
// Description : Directed scoreboard bench for interval_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interval_arbiter;

    localparam int NREQ = 4;
    localparam int CW   = 4;
    localparam int EW   = 2*NREQ + 2 + CW;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b1;
    logic [NREQ-1:0]     req   = '0;
    logic [NREQ*CW-1:0]  dur   = '0;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic                busy;
    logic                cnt_en;
    logic [CW-1:0]       count;

    logic [EW-1:0] exp_q[$];
    string         tag_q[$];
    int            vectors     = 0;
    int            miscompares = 0;

    interval_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .dur    (dur),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy),
        .cnt_en (cnt_en),
        .count  (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected $finish");
        $fatal(1, "watchdog expired");
    end

    // Expected cnt_en is |gnt by definition.
    task automatic push(input string tag, input logic [NREQ-1:0] g, input logic [NREQ-1:0] d,
                        input logic b, input logic [CW-1:0] c);
        exp_q.push_back({g, d, b, (g != '0), c});
        tag_q.push_back(tag);
    endtask

    task automatic push_interval(input string tag, input int owner, input int len);
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << owner;
        for (int k = 0; k < len; k++) push(tag, oh, '0, 1'b1, CW'(k));
        push({tag, "_done"}, '0, oh, 1'b1, '0);
    endtask

    task automatic compare();
        logic [EW-1:0] obs;
        logic [EW-1:0] exv;
        string         tag;
        obs = {gnt, done, busy, cnt_en, count};
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: observed %h, expected an entry", obs);
            return;
        end
        exv = exp_q.pop_front();
        tag = tag_q.pop_front();
        assert (obs === exv) else begin
            miscompares++;
            $error("FAIL %s: observed gnt=%b done=%b busy=%b cnt_en=%b count=%0d, expected gnt=%b done=%b busy=%b cnt_en=%b count=%0d",
                   tag, obs[EW-1 -: NREQ], obs[EW-NREQ-1 -: NREQ], obs[CW+1], obs[CW], obs[CW-1:0],
                   exv[EW-1 -: NREQ], exv[EW-NREQ-1 -: NREQ], exv[CW+1], exv[CW], exv[CW-1:0]);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            compare();
        end
    endtask

    // Asserts reset between edges and checks outputs clear before any edge.
    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        #1;
        push("reset_async", '0, '0, 1'b0, '0);
        compare();
        push("reset_hold", '0, '0, 1'b0, '0);
        tick(1);
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();

        // Single short interval
        dur[0*CW +: CW] = 4'd3;
        req = 4'b0001;
        push_interval("short", 0, 3);
        tick(4);
        req = '0;
        push("short_idle", '0, '0, 1'b0, '0);
        tick(1);

        // Zero duration runs the full 2^CW cycles
        dur[1*CW +: CW] = 4'd0;
        req = 4'b0010;
        push_interval("wrap", 1, 16);
        tick(17);
        req = '0;
        push("wrap_idle", '0, '0, 1'b0, '0);
        tick(1);

        // Continuous contention from ptr=0
        do_reset();
        dur = {4{4'd1}};
        req = 4'b1111;
        for (int r = 0; r < 6; r++) begin
            push_interval("contend", r % 4, 1);
            tick(2);
            if (r < 5) begin
                push("contend_idle", '0, '0, 1'b0, '0);
                tick(1);
            end
        end

        // Rotating priority: 1 just finished, so 2 beats 1
        req = 4'b0110;
        dur[1*CW +: CW] = 4'd1;
        dur[2*CW +: CW] = 4'd2;
        push("rotate_idle", '0, '0, 1'b0, '0);
        tick(1);
        push_interval("rotate2", 2, 2);
        tick(3);
        req = 4'b0010;
        push("rotate_idle2", '0, '0, 1'b0, '0);
        tick(1);
        push_interval("rotate1", 1, 1);
        tick(2);
        req = '0;
        push("rotate_idle3", '0, '0, 1'b0, '0);
        tick(1);

        // Reset mid-run at count=5
        dur[0*CW +: CW] = 4'd8;
        req = 4'b0001;
        for (int k = 0; k < 6; k++) push("midrun", 4'b0001, '0, 1'b1, CW'(k));
        tick(6);
        dur[0*CW +: CW] = 4'd2;
        dur[3*CW +: CW] = 4'd2;
        do_reset();
        req = 4'b1001;
        push_interval("post_reset0", 0, 2);
        tick(3);
        req = 4'b1000;
        push("post_reset_idle", '0, '0, 1'b0, '0);
        tick(1);
        push_interval("post_reset3", 3, 2);
        tick(3);
        req = '0;
        push("post_reset_idle2", '0, '0, 1'b0, '0);
        tick(1);

        // Inputs changed during RUN are ignored
        dur[0*CW +: CW] = 4'd4;
        req = 4'b0001;
        push("latched", 4'b0001, '0, 1'b1, 4'd0);
        push("latched", 4'b0001, '0, 1'b1, 4'd1);
        tick(2);
        dur[0*CW +: CW] = 4'd9;
        req = '0;
        push("latched", 4'b0001, '0, 1'b1, 4'd2);
        push("latched", 4'b0001, '0, 1'b1, 4'd3);
        push("latched_done", '0, 4'b0001, 1'b1, '0);
        for (int k = 0; k < 3; k++) push("latched_idle", '0, '0, 1'b0, '0);
        tick(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/interval_arbiter.md
# interval_arbiter

Round-robin scheduler that shares one CW-bit interval counter among NREQ requesters. A requester raises `req` with a duration. The block grants the counter to one requester at a time, runs it for exactly that many cycles, then pulses `done` to the owner. It sits in front of the team's up-counter datapath, driving its enable, and mirrors the elapsed count.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- CW, 4, counter and duration width

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  NREQ  level request per requester, held until its `done`
- dur  input  NREQ*CW  requested durations, flattened; requester i at [i*CW +: CW]; 0 means 2^CW cycles
- gnt  output  NREQ  one-hot current owner; all-zero when no owner
- done  output  NREQ  one-hot, 1-cycle pulse to the owner at end of its interval
- busy  output  1  high in every state except IDLE
- cnt_en  output  1  enable to the shared counter; equals |gnt
- count  output  CW  elapsed cycles of the current interval

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - gnt=0, done=0, count=0.
  - If any req bit is set, pick the first set bit searching upward from `ptr` with wrap.
  - Latch the owner index and target = dur[owner]; go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - gnt = onehot(owner), cnt_en=1.
  - count starts at 0 and increments by 1 each RUN cycle, with CW-bit wrap.
  - When count == target-1 (mod 2^CW), the next state is DONE. target=0 therefore runs 2^CW cycles.
- DONE:
  - gnt=0, cnt_en=0, done = onehot(owner), count=0.
  - `ptr` is set to (owner+1) mod NREQ; next state IDLE.
- `ptr` reset value is 0, so requester 0 has top priority after reset.
- Latched target and owner are immune to changes on `dur` or `req` during RUN.
  - Dropping req mid-RUN does not abort; the interval completes and `done` still pulses.
- Protocol:
  - The requester must deassert req in the cycle after seeing `done` unless it wants another interval.
  - A req still high in IDLE is treated as a new request, arbitrated fairly via `ptr`.
- Reset (rst_n low, any time including mid-RUN):
  - Immediately forces state=IDLE, gnt=0, done=0, busy=0, cnt_en=0, count=0, ptr=0.
  - Latched owner and target are cleared.

## Timing
- Req sampled high at the edge ending IDLE cycle k → gnt high from cycle k+1.
- Interval of d cycles (d = dur, or 2^CW if dur=0):
  - gnt high for cycles k+1..k+d;
  - done pulses in cycle k+d+1;
  - IDLE in cycle k+d+2.
- Earliest next grant is cycle k+d+3. The minimum period per interval is d+2 cycles.
- busy is high for cycles k+1..k+d+1 (d+1 cycles).
- No combinational path from req or dur to any output; all outputs are registered or decoded from state registers.
- gnt and done are never simultaneously nonzero. At most one bit of each is set.

## Test plan
- **Single short interval:** after reset, req=0001, dur0=3 → gnt=0001 for 3 cycles with count 0,1,2; done=0001 for 1 cycle; busy high 4 cycles; then IDLE with all outputs 0.
- **Zero-duration wrap:** req=0010, dur1=0 → gnt=0010 for 16 cycles with count 0..15; done=0010 once; no early termination at count wrap.
- **Continuous contention:** all four req held high, all dur=1 → grant order 0,1,2,3,0,1; each gnt is 1 cycle, and consecutive grants are 3 cycles apart.
- **Rotating priority:** req1 just completed; then req=0110 in the same IDLE cycle → requester 2 is granted before 1. After 2's done, with req=0010, requester 1 is granted.
- **Reset mid-run:** req0 running with dur=8; pull rst_n low at count=5 → gnt, done, busy, cnt_en, count all 0 in the same cycle. On release with req=1001, requester 0 is granted first (ptr=0).
- **Input changes during RUN:** req0 dur=4; change dur0 to 9 and drop req0 in the 2nd gnt cycle → gnt lasts exactly 4 cycles, done=0001 still pulses, and no re-grant follows.
